// File: rtl/lc3b_control_fsm.sv
// lc3b_control_fsm
//   Microsequencer for the LC-3b datapath. This is a Moore-style fetch/decode/
//   execute FSM that drives every datapath load enable, bus gate, mux select
//   and the ALU opcode. Outputs depend on the current state and IR, with two
//   exceptions: the BR LDPC term uses N/Z/P, and instr_done in S_STW2 uses R.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   IR[15:0]     instruction register contents
//   N, Z, P      condition codes
//   R            memory ready; an access completes in a cycle where R=1
//   aluop[2:0]   ALU operation
//   LDCC/LDIR/LDREG/LDPC/LDMAR/LDMDR   register load enables
//   MEMEN        memory write enable
//   GatePC/GateMDR/GateALU/GateMARMUX  bus drivers (at most one high at a time)
//   MuxALU       0=SR2, 1=imm5
//   MuxAddr1     0=PC, 1=BaseR
//   MuxAddr2     00=zero, 01=off11, 10=off6, 11=off9
//   MuxPC        00=PC+2, 01=bus, 10=address adder
//   instr_done   one-cycle pulse in the last state of each instruction
//   illegal      (only when ILLEGAL_OP_EN is defined) high in S_HALT
//
// Build option: ILLEGAL_OP_EN. When it is defined, an unknown opcode stops the
// FSM in S_HALT until reset. When it is not defined, an unknown opcode is a NOP.
//
// state   | meaning
// S_RST   | post-reset idle, all outputs low
// S_F1    | MAR <- PC, PC <- PC+2
// S_F2    | MDR <- M[MAR], wait on R
// S_F3    | IR <- MDR
// S_DEC   | dispatch on opcode
// S_ALU   | ADD/AND/XOR write-back
// S_BR    | conditional branch
// S_JMP   | PC <- BaseR
// S_LDW1  | MAR <- BaseR + off6
// S_LDW2  | MDR <- M[MAR], wait on R
// S_LDW3  | DR <- MDR
// S_STW1  | MAR <- BaseR + off6
// S_STW2  | M[MAR] <- MDR, wait on R
// S_LEA   | DR <- PC + off9
// S_HALT  | illegal opcode trap (ILLEGAL_OP_EN only)

module lc3b_control_fsm #(
  parameter logic [2:0] ALUOP_ADD = 3'b000,
  parameter logic [2:0] ALUOP_AND = 3'b001,
  parameter logic [2:0] ALUOP_XOR = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        R,
  output logic [2:0]  aluop,
  output logic        LDCC,
  output logic        LDIR,
  output logic        LDREG,
  output logic        LDPC,
  output logic        LDMAR,
  output logic        LDMDR,
  output logic        MEMEN,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic        MuxALU,
  output logic        MuxAddr1,
  output logic [1:0]  MuxAddr2,
  output logic [1:0]  MuxPC,
  output logic        instr_done
`ifdef ILLEGAL_OP_EN
  ,output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,  S_F1   = 4'd1,  S_F2   = 4'd2,  S_F3   = 4'd3,
    S_DEC  = 4'd4,  S_ALU  = 4'd5,  S_BR   = 4'd6,  S_JMP  = 4'd7,
    S_LDW1 = 4'd8,  S_LDW2 = 4'd9,  S_LDW3 = 4'd10, S_STW1 = 4'd11,
    S_STW2 = 4'd12, S_LEA  = 4'd13, S_HALT = 4'd14
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_opcode;
  logic       w_unused;

  assign w_opcode = IR[15:12];
  // Register and offset fields belong to the datapath, not to this FSM.
  assign w_unused = &{1'b0, IR[8:6], IR[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    aluop      = ALUOP_ADD;
    LDCC       = 1'b0;
    LDIR       = 1'b0;
    LDREG      = 1'b0;
    LDPC       = 1'b0;
    LDMAR      = 1'b0;
    LDMDR      = 1'b0;
    MEMEN      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    MuxALU     = 1'b0;
    MuxAddr1   = 1'b0;
    MuxAddr2   = 2'b00;
    MuxPC      = 2'b00;
    instr_done = 1'b0;
`ifdef ILLEGAL_OP_EN
    illegal    = 1'b0;
`endif
    case (r_state)
      S_RST: w_next = S_F1;
      S_F1: begin
        GatePC = 1'b1;
        LDMAR  = 1'b1;
        LDPC   = 1'b1;
        w_next = S_F2;
      end
      S_F2: begin
        LDMDR = 1'b1;
        if (R) w_next = S_F3;
      end
      S_F3: begin
        LDIR   = 1'b1;
        w_next = S_DEC;
      end
      S_DEC: begin
        case (w_opcode)
          4'b0001, 4'b0101, 4'b1001: w_next = S_ALU;
          4'b0000:                   w_next = S_BR;
          4'b1100:                   w_next = S_JMP;
          4'b0110:                   w_next = S_LDW1;
          4'b0111:                   w_next = S_STW1;
          4'b1110:                   w_next = S_LEA;
          default: begin
`ifdef ILLEGAL_OP_EN
            w_next = S_HALT;
`else
            instr_done = 1'b1;
            w_next     = S_F1;
`endif
          end
        endcase
      end
      S_ALU: begin
        case (w_opcode)
          4'b0101: aluop = ALUOP_AND;
          4'b1001: aluop = ALUOP_XOR;
          default: aluop = ALUOP_ADD;
        endcase
        MuxALU     = IR[5];
        GateALU    = 1'b1;
        LDREG      = 1'b1;
        LDCC       = 1'b1;
        instr_done = 1'b1;
        w_next     = S_F1;
      end
      S_BR: begin
        MuxAddr2   = 2'b11;
        MuxPC      = 2'b10;
        LDPC       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
        instr_done = 1'b1;
        w_next     = S_F1;
      end
      S_JMP: begin
        MuxAddr1   = 1'b1;
        MuxPC      = 2'b10;
        LDPC       = 1'b1;
        instr_done = 1'b1;
        w_next     = S_F1;
      end
      S_LDW1, S_STW1: begin
        MuxAddr1   = 1'b1;
        MuxAddr2   = 2'b10;
        GateMARMUX = 1'b1;
        LDMAR      = 1'b1;
        w_next     = (r_state == S_LDW1) ? S_LDW2 : S_STW2;
      end
      S_LDW2: begin
        LDMDR = 1'b1;
        if (R) w_next = S_LDW3;
      end
      S_LDW3: begin
        GateMDR    = 1'b1;
        LDREG      = 1'b1;
        LDCC       = 1'b1;
        instr_done = 1'b1;
        w_next     = S_F1;
      end
      S_STW2: begin
        MEMEN = 1'b1;
        // The store retires in the cycle the memory accepts it.
        if (R) begin
          instr_done = 1'b1;
          w_next     = S_F1;
        end
      end
      S_LEA: begin
        MuxAddr2   = 2'b11;
        GateMARMUX = 1'b1;
        LDREG      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_F1;
      end
      S_HALT: begin
`ifdef ILLEGAL_OP_EN
        illegal = 1'b1;
`endif
        w_next = S_HALT;
      end
      default: w_next = S_RST;
    endcase
  end

endmodule
